// File: rtl/adc_card_pkg.sv
// Shared types and constants for the ADC-driven tarot card sampler.
package adc_card_pkg;

    // Draw controller states
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_EVAL,
        S_CHECK,
        S_ERR
    } state_t;

    localparam int NUM_CARDS_DEF = 78;
    localparam int IDX_W_DEF     = 7;

    // Field positions in the von Neumann decode result {keep, bit}
    localparam int PAIR_KEEP = 1;
    localparam int PAIR_BIT  = 0;

    // Von Neumann decode: unequal pairs are kept and yield the earlier bit,
    // so (0,1) -> 0 and (1,0) -> 1; equal pairs are discarded.
    function automatic logic [1:0] pair_decode(input logic first, input logic second);
        return {first != second, first};
    endfunction

endpackage

// File: rtl/adc_card_sampler_sync.sv
// Multi-flop synchronizer for a single asynchronous level, plus a rising-edge pulse.
module adc_valid_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic async_in,
    output logic rise
);

    // Stages 0..STAGES-1 form the synchronizer; the extra stage remembers the
    // previous synchronized value for edge detection.
    logic [STAGES:0] sync_reg;

    genvar gi;
    generate
        for (gi = 0; gi <= STAGES; gi++) begin : g_stage
            // Each stage samples the one before it (stage 0 samples the raw input)
            always_ff @(posedge clk) begin
                if (srst) begin
                    sync_reg[gi] <= 1'b0;
                end else if (gi == 0) begin
                    sync_reg[gi] <= async_in;
                end else begin
                    sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    assign rise = sync_reg[STAGES-1] & ~sync_reg[STAGES];

endmodule

// File: rtl/adc_card_sampler.sv
// Requests ADC conversions, harvests one noise bit per sample, debiases the
// bits in von Neumann pairs and assembles a uniformly distributed card index
// plus an upright/reversed flag, using rejection sampling for out-of-range draws.
module adc_card_sampler
    import adc_card_pkg::*;
#(
    parameter int NUM_CARDS = NUM_CARDS_DEF,
    parameter int IDX_W     = IDX_W_DEF,
    parameter int ENT_BIT   = 0,
    parameter int TIMEOUT   = 65535
) (
    input  logic             clk,
    input  logic             rstn,        // synchronous, active-high
    input  logic             start,
    output logic             adc_ready,
    input  logic             adc_valid,
    input  logic [11:0]      adc_data,
    output logic             busy,
    output logic             card_valid,
    output logic [IDX_W-1:0] card_idx,
    output logic             card_rev,
    output logic             error
);

    localparam int SH_W = IDX_W + 1;
    localparam int CW   = $clog2(SH_W + 1);
    localparam int TW   = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0]    COUNT_FULL = CW'(SH_W);
    localparam logic [TW-1:0]    TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [IDX_W:0]   CARDS_LIM  = (IDX_W + 1)'(NUM_CARDS);

    state_t            state_reg, state_next;
    logic [SH_W-1:0]   shift_reg, shift_next;
    logic [CW-1:0]     count_reg, count_next;
    logic              pend_reg, pend_next;
    logic              pend_valid_reg, pend_valid_next;
    logic              bit_reg, bit_next;
    logic [TW-1:0]     tmo_reg, tmo_next;
    logic              error_reg, error_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic              rev_reg, rev_next;

    logic              vrise;
    logic [1:0]        pair;
    logic              accept;
    logic              unused_data_bits;

    // Only one bit of each sample carries entropy
    assign unused_data_bits = ^adc_data;

    adc_valid_sync #(
        .STAGES (2)
    ) u_valid_sync (
        .clk      (clk),
        .srst     (rstn),
        .async_in (adc_valid),
        .rise     (vrise)
    );

    assign pair   = pair_decode(pend_reg, bit_reg);
    assign accept = {1'b0, shift_reg[IDX_W:1]} < CARDS_LIM;

    // Next-state, datapath updates and Moore/Mealy outputs for the draw FSM
    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        count_next      = count_reg;
        pend_next       = pend_reg;
        pend_valid_next = pend_valid_reg;
        bit_next        = bit_reg;
        tmo_next        = tmo_reg;
        error_next      = error_reg;
        idx_next        = idx_reg;
        rev_next        = rev_reg;
        adc_ready       = 1'b0;
        busy            = 1'b0;
        card_valid      = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    error_next      = 1'b0;
                    shift_next      = '0;
                    count_next      = '0;
                    pend_valid_next = 1'b0;
                    tmo_next        = '0;
                    state_next      = S_REQ;
                end
            end
            S_REQ: begin
                adc_ready = 1'b1;
                busy      = 1'b1;
                if (vrise) begin
                    // valid is still high here, so the data bus is stable
                    bit_next   = adc_data[ENT_BIT];
                    tmo_next   = '0;
                    state_next = S_EVAL;
                end else if (tmo_reg == TMO_LAST) begin
                    tmo_next   = '0;
                    error_next = 1'b1;
                    state_next = S_ERR;
                end else begin
                    tmo_next = tmo_reg + 1'b1;
                end
            end
            S_EVAL: begin
                // ready stays high so the driver starts the next conversion at once
                adc_ready = 1'b1;
                busy      = 1'b1;
                if (!pend_valid_reg) begin
                    pend_next       = bit_reg;
                    pend_valid_next = 1'b1;
                    state_next      = S_REQ;
                end else begin
                    pend_valid_next = 1'b0;
                    if (pair[PAIR_KEEP]) begin
                        shift_next = {shift_reg[SH_W-2:0], pair[PAIR_BIT]};
                        count_next = count_reg + 1'b1;
                    end
                    state_next = (count_next == COUNT_FULL) ? S_CHECK : S_REQ;
                end
            end
            S_CHECK: begin
                if (accept) begin
                    card_valid = 1'b1;
                    idx_next   = shift_reg[IDX_W:1];
                    rev_next   = shift_reg[0];
                    state_next = S_IDLE;
                end else begin
                    // Out of range: throw the whole draw away to keep it uniform
                    busy       = 1'b1;
                    shift_next = '0;
                    count_next = '0;
                    state_next = S_REQ;
                end
            end
            S_ERR: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_reg      <= S_IDLE;
            shift_reg      <= '0;
            count_reg      <= '0;
            pend_reg       <= 1'b0;
            pend_valid_reg <= 1'b0;
            bit_reg        <= 1'b0;
            tmo_reg        <= '0;
            error_reg      <= 1'b0;
            idx_reg        <= '0;
            rev_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            count_reg      <= count_next;
            pend_reg       <= pend_next;
            pend_valid_reg <= pend_valid_next;
            bit_reg        <= bit_next;
            tmo_reg        <= tmo_next;
            error_reg      <= error_next;
            idx_reg        <= idx_next;
            rev_reg        <= rev_next;
        end
    end

    // The new card is presented during the accepting cycle, then held
    assign card_idx = card_valid ? shift_reg[IDX_W:1] : idx_reg;
    assign card_rev = card_valid ? shift_reg[0]       : rev_reg;
    assign error    = error_reg;

endmodule

// File: tb/tb_adc_card_sampler.sv
// Scoreboard bench for adc_card_sampler: directed ADC bit streams, expected
// cards queued at stimulus time and checked by an independent monitor.
module tb_adc_card_sampler;

    localparam int IDX_W = 7;

    logic             clk = 1'b0;
    logic             rstn;
    logic             start;
    logic             adc_ready;
    logic             adc_valid;
    logic [11:0]      adc_data;
    logic             busy;
    logic             card_valid;
    logic [IDX_W-1:0] card_idx;
    logic             card_rev;
    logic             error;

    typedef struct {
        int idx;
        int rev;
    } card_t;

    card_t exp_q[$];
    bit    bit_q[$];
    int    checks     = 0;
    int    errors     = 0;
    int    conv_count = 0;
    int    cv_count   = 0;
    bit    mute       = 1'b0;

    always #5 clk = ~clk;

    adc_card_sampler #(
        .NUM_CARDS (78),
        .IDX_W     (IDX_W),
        .ENT_BIT   (0),
        .TIMEOUT   (100)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .adc_ready  (adc_ready),
        .adc_valid  (adc_valid),
        .adc_data   (adc_data),
        .busy       (busy),
        .card_valid (card_valid),
        .card_idx   (card_idx),
        .card_rev   (card_rev),
        .error      (error)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ADC driver model: one conversion per request, bits taken from bit_q
    initial begin
        bit b;
        forever begin
            @(negedge clk);
            if (adc_ready && !mute) begin
                repeat (2) @(negedge clk);
                b = (bit_q.size() > 0) ? bit_q.pop_front() : 1'b0;
                adc_data  = {11'($urandom), b};
                adc_valid = 1'b1;
                conv_count++;
                repeat (4) @(negedge clk);
                adc_valid = 1'b0;
                repeat (3) @(negedge clk);
            end
        end
    end

    // Monitor: every card_valid pulse is matched against the scoreboard
    initial begin
        card_t e;
        forever begin
            @(negedge clk);
            if (card_valid) begin
                cv_count++;
                $display("card idx=%0d rev=%0d conversions=%0d", card_idx, card_rev, conv_count);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_card: got idx %0d expected no card", card_idx);
                end else begin
                    e = exp_q.pop_front();
                    chk("card_idx", int'(card_idx), e.idx);
                    chk("card_rev", int'(card_rev), e.rev);
                end
            end
        end
    end

    task automatic load_stream(input logic [63:0] s, input int n);
        bit_q.delete();
        for (int i = 0; i < n; i++) bit_q.push_back(s[n-1-i]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One complete draw; optionally pokes start again while busy
    task automatic run_draw(input string name, input logic [63:0] s, input int n,
                            input int exp_idx, input int exp_rev, input int exp_conv,
                            input bit poke);
        int  cv0;
        bit  done;
        card_t e;
        load_stream(s, n);
        conv_count = 0;
        cv0 = cv_count;
        e.idx = exp_idx;
        e.rev = exp_rev;
        exp_q.push_back(e);
        pulse_start();
        chk({name, "_error_cleared"}, int'(error), 0);
        chk({name, "_busy"}, int'(busy), 1);
        done = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) begin
            start = (poke && i == 40);
            if (card_valid) done = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        if (!done) chk({name, "_card_timeout"}, 0, 1);
        repeat (10) @(negedge clk);
        chk({name, "_conversions"}, conv_count, exp_conv);
        chk({name, "_cards"}, cv_count - cv0, 1);
        chk({name, "_error"}, int'(error), 0);
        chk({name, "_busy_after"}, int'(busy), 0);
        chk({name, "_scoreboard_empty"}, exp_q.size(), 0);
        $display("draw %s done: conversions=%0d", name, conv_count);
    endtask

    initial begin
        int cnt;
        int cv0;
        rstn      = 1'b1;
        start     = 1'b0;
        adc_valid = 1'b0;
        adc_data  = '0;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("rst_adc_ready", int'(adc_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_card_valid", int'(card_valid), 0);
        chk("rst_card_idx", int'(card_idx), 0);
        chk("rst_card_rev", int'(card_rev), 0);
        chk("rst_error", int'(error), 0);

        // Basic draw: 0000101,1 -> idx 5 reversed
        run_draw("basic", 64'h559A, 16, 5, 1, 16, 1'b0);

        // Equal pairs (0,0),(1,1) before the third pair are discarded
        run_draw("discard", 64'h5359A, 20, 5, 1, 20, 1'b0);

        // idx 127 is rejected, then 1001101,0 -> idx 77 upright
        run_draw("reject", 64'hAAA99699, 32, 77, 0, 32, 1'b0);

        // A second start while busy is ignored
        run_draw("start_busy", 64'h559A, 16, 5, 1, 16, 1'b1);

        // Reset mid-draw after 5 conversions
        load_stream(64'h559A, 16);
        conv_count = 0;
        pulse_start();
        cnt = 0;
        while (conv_count < 5 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        chk("midrst_reached_5", conv_count, 5);
        rstn = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
        chk("midrst_adc_ready", int'(adc_ready), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_card_valid", int'(card_valid), 0);
        chk("midrst_card_idx", int'(card_idx), 0);
        repeat (20) @(negedge clk);
        run_draw("after_reset", 64'h559A, 16, 5, 1, 16, 1'b0);

        // Timeout: ADC never answers
        mute = 1'b1;
        cv0 = cv_count;
        pulse_start();
        cnt = 0;
        while (adc_ready && cnt < 300) begin
            cnt++;
            @(negedge clk);
        end
        chk("timeout_ready_cycles", cnt, 100);
        chk("timeout_error", int'(error), 1);
        chk("timeout_busy", int'(busy), 0);
        repeat (5) @(negedge clk);
        chk("timeout_error_sticky", int'(error), 1);
        chk("timeout_no_card", cv_count - cv0, 0);
        mute = 1'b0;
        run_draw("after_timeout", 64'h559A, 16, 5, 1, 16, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/adc_card_sampler.md
Name: adc_card_sampler

Overview:
- Downstream consumer and request controller for the MCP3202 SPI driver.
- On a start pulse it requests ADC conversions one after another and takes one noise bit from each 12-bit sample.
- It debiases those bits (von Neumann pairs) and assembles a uniformly distributed tarot card index (0..NUM_CARDS-1) plus an upright/reversed flag.
- Results go to the card display/UI logic.

Parameters:
- NUM_CARDS, 78, number of valid card indices; must be ≤ 2^IDX_W
- IDX_W, 7, card index width
- ENT_BIT, 0, bit position of adc_data used as the entropy bit
- TIMEOUT, 65535, clk cycles allowed per conversion before error

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous, active-high reset (despite the name)
- start  in  1  one-cycle request for a new card
- adc_ready  out  1  conversion request to the ADC driver (driver ap_ready)
- adc_valid  in  1  driver ap_vaild; asynchronous to clk
- adc_data  in  12  driver data; stable while adc_valid is high
- busy  out  1  high from accepted start until card_valid or error
- card_valid  out  1  one-cycle pulse; card_idx/card_rev valid
- card_idx  out  IDX_W  selected card, held until next card_valid
- card_rev  out  1  1 = reversed, held until next card_valid
- error  out  1  sticky timeout flag; cleared by the next accepted start or reset

Behaviour:
- Reset:
  - all outputs 0; FSM in S_IDLE.
  - shift register, bit count, pending-bit flag and timeout counter cleared.
  - Reset mid-operation aborts the draw immediately; adc_ready drops in the same cycle the reset is sampled.
- adc_valid path:
  - 2-flop synchronizer, then rising-edge detect (vrise).
  - adc_data is captured on the cycle vrise is seen (data is stable because valid is still high).
- States:
  - S_IDLE:
    - adc_ready=0, busy=0.
    - start=1 → clear error, shift reg, count and pending flag; go to S_REQ.
  - S_REQ:
    - adc_ready=1, timeout counter increments each cycle.
    - vrise → capture bit b = adc_data[ENT_BIT], reset timeout counter, go to S_EVAL.
    - Counter reaches TIMEOUT-1 with no vrise → S_ERR.
  - S_EVAL (1 cycle; adc_ready held 1 so the driver restarts its next conversion):
    - No pending bit → store b as pending; go to S_REQ.
    - Pending p, with p≠b → shift p into the LSB of the (IDX_W+1)-bit shift reg, count+1; clear pending.
      - Pair (0,1) yields 0; pair (1,0) yields 1.
    - Pending p, with p==b → discard both bits, clear pending.
    - Then count==IDX_W+1 → S_CHECK, else S_REQ.
  - S_CHECK (1 cycle, adc_ready=0):
    - Field split: idx = shift[IDX_W:1], rev = shift[0].
    - idx < NUM_CARDS → load card_idx/card_rev, pulse card_valid, go to S_IDLE. busy falls in the same cycle card_valid is high.
    - Otherwise (rejection sampling) clear count and shift reg, go to S_REQ.
  - S_ERR (1 cycle):
    - adc_ready=0, error=1, go to S_IDLE.
- start while busy is ignored.
- Latency: with no discards, a card needs 2·(IDX_W+1)=16 conversions. card_valid is asserted 1 cycle after the S_EVAL that completes the 8th bit.
- The first bit of each pair is taken from the earlier sample. The shift register is MSB-first: the first debiased bit becomes card_idx[IDX_W-1].

Decomposition:
- Package adc_card_pkg holds:
  - state enum (S_IDLE, S_REQ, S_EVAL, S_CHECK, S_ERR)
  - NUM_CARDS_DEF=78, IDX_W_DEF=7
  - pair-decode constants
- One sub-module, adc_valid_sync: 2-flop synchronizer plus rising-edge pulse on a 1-bit input, with synchronous active-high reset.

Test Plan:
- Basic draw. ADC model returns LSBs 0,1, 0,1, 0,1, 0,1, 1,0, 0,1, 1,0, 1,0 → one card_valid pulse with card_idx=5 and card_rev=1; exactly 16 adc_valid rises consumed; error=0.
- Discard pairs. Same stream with pairs (0,0) and (1,1) inserted before the 3rd pair → card_idx=5, card_rev=1 after 20 conversions.
- Rejection. First 8 debiased bits are 1111111,0 (idx 127) → no card_valid. Next 8 bits are 1001101,0 → card_idx=77, card_rev=0; 32 conversions total.
- Timeout. TIMEOUT=100, model never raises adc_valid:
  - adc_ready high for 100 cycles, then drops.
  - error=1 and busy=0; card_valid never pulses.
  - A new start clears error.
- Reset mid-draw. Assert rstn for 1 cycle after 5 conversions:
  - the next cycle shows adc_ready=0, busy=0, card_valid=0, card_idx=0;
  - a fresh start with the basic-draw stream again yields card_idx=5.
- Start while busy. Pulse start again during the draw → ignored; exactly one card_valid; conversion count unchanged at 16.
